// File: rtl/loop_nest_seq.sv
`default_nettype none
// ============================================================================
//  Module      : loop_nest_seq
//  Description : Two-level loop-nest index sequencer. Emits the index pairs
//                (i, j) of "for i < n_outer, for j < n_inner" on a
//                valid/ready stream. An optional product limit stops the
//                sequence at the first pair where i*j >= limit.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                start                - begin a sequence (accepted in IDLE)
//                n_outer, n_inner     - trip counts, latched on start
//                limit_en, limit      - early-exit product limit, latched
//                out_valid/out_ready  - output handshake
//                out_i, out_j         - current index pair
//                out_last             - final pair of the sequence
//                busy                 - sequence in progress
//                done                 - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_nest_seq #(
    parameter int IW = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] n_outer,
    input  logic [IW-1:0] n_inner,
    input  logic          limit_en,
    input  logic [PW-1:0] limit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_i,
    output logic [IW-1:0] out_j,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [IW-1:0] C_ZERO_I = '0;
    localparam logic [IW-1:0] C_ONE_I  = IW'(1);
    localparam logic [IW:0]   C_ONE_W  = (IW+1)'(1);

    state_t        state_q;
    logic [IW-1:0] n_outer_q;
    logic [IW-1:0] n_inner_q;
    logic          limit_en_q;
    logic [PW-1:0] limit_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic          valid_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;

    logic [2*IW-1:0] nxt_d;         // {i', j'} following the current pair
    logic            nxt_last_d;    // whether {i', j'} is itself the final pair
    logic            first_last_d;  // whether (0,0) is final under new config
    logic            empty_d;       // new config produces no pairs at all

    // Loop advance: step j, wrapping into i at the end of the inner loop.
    // i never overflows: a sequence always ends at i' == n_outer first.
    function automatic logic [2*IW-1:0] adv_pair(
        input logic [IW-1:0] i,
        input logic [IW-1:0] j,
        input logic [IW-1:0] nin
    );
        logic [IW:0] j_inc;
        j_inc = {1'b0, j} + C_ONE_W;
        if (j_inc < {1'b0, nin}) begin
            adv_pair = {i, j_inc[IW-1:0]};
        end else begin
            adv_pair = {i + C_ONE_I, C_ZERO_I};
        end
    endfunction

    // Loop-condition failure for a candidate pair.
    function automatic logic ends_at(
        input logic [IW-1:0] i,
        input logic [IW-1:0] j,
        input logic [IW-1:0] nout,
        input logic          le,
        input logic [PW-1:0] lim
    );
        logic [2*IW-1:0] prod;
        prod    = (2*IW)'(i) * (2*IW)'(j);
        ends_at = (i == nout) || (le && (PW'(prod) >= lim));
    endfunction

    // A pair is final when its successor fails the loop condition.
    function automatic logic is_last(
        input logic [IW-1:0] i,
        input logic [IW-1:0] j,
        input logic [IW-1:0] nin,
        input logic [IW-1:0] nout,
        input logic          le,
        input logic [PW-1:0] lim
    );
        logic [2*IW-1:0] nx;
        nx      = adv_pair(i, j, nin);
        is_last = ends_at(nx[2*IW-1:IW], nx[IW-1:0], nout, le, lim);
    endfunction

    always_comb begin
        nxt_d        = adv_pair(i_q, j_q, n_inner_q);
        // Lookahead one pair so out_last can be registered alongside the pair.
        nxt_last_d   = is_last(nxt_d[2*IW-1:IW], nxt_d[IW-1:0],
                               n_inner_q, n_outer_q, limit_en_q, limit_q);
        first_last_d = is_last(C_ZERO_I, C_ZERO_I,
                               n_inner, n_outer, limit_en, limit);
        empty_d      = (n_outer == C_ZERO_I) || (n_inner == C_ZERO_I) ||
                       (limit_en && (limit == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_outer_q  <= '0;
            n_inner_q  <= '0;
            limit_en_q <= 1'b0;
            limit_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_outer_q  <= n_outer;
                        n_inner_q  <= n_inner;
                        limit_en_q <= limit_en;
                        limit_q    <= limit;
                        i_q        <= '0;
                        j_q        <= '0;
                        if (empty_d) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            last_q  <= first_last_d;
                        end
                    end
                end
                S_RUN: begin
                    if (valid_q && out_ready) begin
                        if (last_q) begin
                            state_q <= S_FIN;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            i_q     <= '0;
                            j_q     <= '0;
                        end else begin
                            i_q    <= nxt_d[2*IW-1:IW];
                            j_q    <= nxt_d[IW-1:0];
                            last_q <= nxt_last_d;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_i     = i_q;
    assign out_j     = j_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loop_nest_seq
//  Description : Directed self-checking bench for loop_nest_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_nest_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n_outer;
    logic [3:0] n_inner;
    logic       limit_en;
    logic [7:0] limit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_i;
    logic [3:0] out_j;
    logic       out_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    int obs_i [0:255];
    int obs_j [0:255];
    int obs_l [0:255];
    int exp_i [0:255];
    int exp_j [0:255];
    int n_obs, n_exp;
    int done_at, first_at, hold_bad, busy_bad;

    loop_nest_seq #(.IW(4), .PW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_outer  (n_outer),
        .n_inner  (n_inner),
        .limit_en (limit_en),
        .limit    (limit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_i    (out_i),
        .out_j    (out_j),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive config, pulse start across one edge.
    task automatic launch(input int no, input int ni, input logic le, input int lim);
        n_outer  = 4'(no);
        n_inner  = 4'(ni);
        limit_en = le;
        limit    = 8'(lim);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Observes the stream after an accepted start until done or budget.
    // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1 repeating.
    // inj_at: cycle at which a second start with other counts is driven.
    task automatic collect(input int rmode, input int inj_at, input int max_cyc);
        int   pi, pj, pl;
        logic stall;
        for (int k = 0; k < 256; k++) begin
            obs_i[k] = -1; obs_j[k] = -1; obs_l[k] = -1;
        end
        n_obs = 0; done_at = -1; first_at = -1; hold_bad = 0; busy_bad = 0;
        stall = 1'b0; pi = 0; pj = 0; pl = 0;
        for (int c = 1; c <= max_cyc && done_at < 0; c++) begin
            if (rmode == 1) out_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            else            out_ready = 1'b1;
            if (c == inj_at) begin
                start = 1'b1; n_outer = 4'd5; n_inner = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (stall && (int'(out_i) != pi || int'(out_j) != pj || int'(out_last) != pl))
                hold_bad++;
            if (out_valid === 1'b1 && first_at < 0) first_at = c;
            if (busy !== out_valid) busy_bad++;
            if (out_valid === 1'b1 && out_ready === 1'b1 && n_obs < 256) begin
                obs_i[n_obs] = int'(out_i);
                obs_j[n_obs] = int'(out_j);
                obs_l[n_obs] = int'(out_last);
                n_obs++;
            end
            stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            pi = int'(out_i); pj = int'(out_j); pl = int'(out_last);
            if (done === 1'b1) done_at = c;
            else tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_valid, out_i, out_j, out_last, busy, done} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b i=%0d j=%0d l=%b b=%b d=%b required all 0",
                     out_valid, out_i, out_j, out_last, busy, done);
        end
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset: got v=%b b=%b d=%b required 0", out_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        n_exp = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) begin
                exp_i[n_exp] = i; exp_j[n_exp] = j; n_exp++;
            end
        launch(2, 3, 1'b0, 0);
        collect(0, 0, 50);
        n_checks++;
        if (first_at !== 1) begin
            n_errors++; $display("FAIL basic_latency: got %0d required 1", first_at);
        end
        n_checks++;
        if (n_obs !== 6) begin
            n_errors++; $display("FAIL basic_count: got %0d required 6", n_obs);
        end
        for (int k = 0; k < n_exp; k++) begin
            n_checks++;
            if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_l[k] !== int'(k == n_exp - 1)) begin
                n_errors++;
                $display("FAIL basic_pair%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         k, obs_i[k], obs_j[k], obs_l[k], exp_i[k], exp_j[k], int'(k == n_exp - 1));
            end
        end
        n_checks++;
        if (done_at !== 7) begin
            n_errors++; $display("FAIL basic_done_cycle: got %0d required 7", done_at);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_errors++; $display("FAIL basic_busy: got %0d mismatching cycles required 0", busy_bad);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++; $display("FAIL basic_done_width: got %b required 0", done);
        end
    endtask

    task automatic test_limit();
        n_exp = 0;
        for (int j = 0; j < 8; j++) begin exp_i[n_exp] = 0; exp_j[n_exp] = j; n_exp++; end
        for (int j = 0; j < 6; j++) begin exp_i[n_exp] = 1; exp_j[n_exp] = j; n_exp++; end
        launch(8, 8, 1'b1, 6);
        collect(0, 0, 100);
        n_checks++;
        if (n_obs !== 14) begin
            n_errors++; $display("FAIL limit_count: got %0d required 14", n_obs);
        end
        for (int k = 0; k < n_exp; k++) begin
            n_checks++;
            if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_l[k] !== int'(k == n_exp - 1)) begin
                n_errors++;
                $display("FAIL limit_pair%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         k, obs_i[k], obs_j[k], obs_l[k], exp_i[k], exp_j[k], int'(k == n_exp - 1));
            end
        end
        n_checks++;
        if (done_at !== 15) begin
            n_errors++; $display("FAIL limit_done_cycle: got %0d required 15", done_at);
        end
        tick();
    endtask

    task automatic test_empty();
        // three ways of producing an empty sequence
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       launch(0, 5, 1'b0, 0);
                1:       launch(3, 0, 1'b0, 0);
                default: launch(3, 3, 1'b1, 0);
            endcase
            collect(0, 0, 20);
            n_checks++;
            if (n_obs !== 0 || first_at !== -1) begin
                n_errors++; $display("FAIL empty%0d_pairs: got %0d pairs required 0", t, n_obs);
            end
            n_checks++;
            if (done_at !== 1) begin
                n_errors++; $display("FAIL empty%0d_done_cycle: got %0d required 1", t, done_at);
            end
            n_checks++;
            if (busy_bad !== 0) begin
                n_errors++; $display("FAIL empty%0d_busy: got %0d busy cycles required 0", t, busy_bad);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        launch(2, 2, 1'b0, 0);
        collect(1, 0, 50);
        n_checks++;
        if (n_obs !== 4) begin
            n_errors++; $display("FAIL stall_count: got %0d required 4", n_obs);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_i[k] !== k / 2 || obs_j[k] !== k % 2 || obs_l[k] !== int'(k == 3)) begin
                n_errors++;
                $display("FAIL stall_pair%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         k, obs_i[k], obs_j[k], obs_l[k], k / 2, k % 2, int'(k == 3));
            end
        end
        n_checks++;
        if (hold_bad !== 0) begin
            n_errors++; $display("FAIL stall_hold: got %0d unstable cycles required 0", hold_bad);
        end
        n_checks++;
        if (done_at !== 9) begin
            n_errors++; $display("FAIL stall_done_cycle: got %0d required 9", done_at);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        launch(2, 3, 1'b0, 0);
        collect(0, 3, 50);
        n_checks++;
        if (n_obs !== 6) begin
            n_errors++; $display("FAIL busy_start_count: got %0d required 6", n_obs);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (obs_i[k] !== k / 3 || obs_j[k] !== k % 3 || obs_l[k] !== int'(k == 5)) begin
                n_errors++;
                $display("FAIL busy_start_pair%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         k, obs_i[k], obs_j[k], obs_l[k], k / 3, k % 3, int'(k == 5));
            end
        end
        tick();
    endtask

    task automatic test_max_count();
        // full 15x15 walk; the limit never triggers (14*14 = 196 < 200)
        launch(15, 15, 1'b1, 200);
        collect(0, 0, 400);
        n_checks++;
        if (n_obs !== 225) begin
            n_errors++; $display("FAIL max_count: got %0d required 225", n_obs);
        end
        n_checks++;
        if (obs_i[224] !== 14 || obs_j[224] !== 14 || obs_l[224] !== 1 || obs_l[223] !== 0) begin
            n_errors++;
            $display("FAIL max_last_pair: got (%0d,%0d,last=%0d) required (14,14,last=1)",
                     obs_i[224], obs_j[224], obs_l[224]);
        end
        n_checks++;
        if (obs_i[15] !== 1 || obs_j[15] !== 0) begin
            n_errors++; $display("FAIL max_wrap: got (%0d,%0d) required (1,0)", obs_i[15], obs_j[15]);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        launch(2, 3, 1'b0, 0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_i !== 4'd0 || out_j !== 4'd0) begin
            n_errors++;
            $display("FAIL midreset_clear: got v=%b b=%b i=%0d j=%0d required 0", out_valid, busy, out_i, out_j);
        end
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1 || out_valid === 1'b1) seen_done++;
            tick();
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_errors++; $display("FAIL midreset_quiet: got %0d active cycles required 0", seen_done);
        end
        launch(2, 3, 1'b0, 0);
        collect(0, 0, 50);
        n_checks++;
        if (n_obs !== 6 || obs_i[0] !== 0 || obs_j[0] !== 0 || obs_l[5] !== 1) begin
            n_errors++;
            $display("FAIL midreset_rerun: got %0d pairs first (%0d,%0d) required 6 pairs first (0,0)",
                     n_obs, obs_i[0], obs_j[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        launch(1, 2, 1'b0, 0);
        collect(0, 0, 20);
        n_checks++;
        if (done_at !== 3) begin
            n_errors++; $display("FAIL b2b_done_cycle: got %0d required 3", done_at);
        end
        // start raised while done is high must be ignored
        n_outer = 4'd1; n_inner = 4'd1; limit_en = 1'b0; start = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL b2b_ignored: got v=%b d=%b required v=0 d=0", out_valid, done);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_i !== 4'd0 || out_j !== 4'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_accept: got v=%b l=%b i=%0d j=%0d b=%b required v=1 l=1 (0,0) b=1",
                     out_valid, out_last, out_i, out_j, busy);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_single_done: got d=%b v=%b required d=1 v=0", done, out_valid);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; n_outer = '0; n_inner = '0;
        limit_en = 1'b0; limit = '0; out_ready = 1'b0;
        tick(); tick();
        test_reset();
        test_basic();
        test_limit();
        test_empty();
        test_stall();
        test_start_while_busy();
        test_max_count();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
